// File: rtl/ascii_sep_pkg.sv
// Shared types, ASCII constants and byte classifier for the streaming decimal parser.
package ascii_sep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_SIGN,
        ST_DIGIT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CC_DIGIT,
        CC_SIGN,
        CC_DELIM,
        CC_ILLEGAL
    } char_class_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    function automatic char_class_t classify(input logic [7:0] ch);
        char_class_t cc;
        if (ch >= ASCII_ZERO && ch <= ASCII_NINE)
            cc = CC_DIGIT;
        else if (ch == ASCII_MINUS)
            cc = CC_SIGN;
        else if (ch == ASCII_SPACE || ch == ASCII_COMMA || ch == ASCII_CR || ch == ASCII_LF)
            cc = CC_DELIM;
        else
            cc = CC_ILLEGAL;
        return cc;
    endfunction

endpackage

// File: rtl/ascii_stream_num_parser_if.sv
// Byte-stream input and RAM write port of the decimal parser.
interface ascii_stream_num_parser_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
);
    logic [7:0]            pkt_payload_data;
    logic                  pkt_payload_valid;
    logic                  pkt_payload_last;
    logic                  pkt_payload_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output pkt_payload_data, pkt_payload_valid, pkt_payload_last,
        input  pkt_payload_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  pkt_payload_data, pkt_payload_valid, pkt_payload_last,
        output pkt_payload_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/dec_accumulator.sv
// Decimal digit accumulator: acc*10 + digit, clamped to the signed limit of DATA_WIDTH.
module dec_accumulator #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH+3:0] acc,
    input  logic [3:0]            digit,
    input  logic                  neg,
    output logic [DATA_WIDTH+3:0] acc_nxt,
    output logic                  ovf
);
    localparam int AW = DATA_WIDTH + 4;
    localparam logic [AW-1:0] POS_LIM = {5'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [AW-1:0] NEG_LIM = {4'b0, 1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [AW-1:0] prod;
    logic [AW-1:0] lim;

    // acc never exceeds NEG_LIM, so the product always fits in DATA_WIDTH+4 bits
    always_comb begin
        prod    = (acc << 3) + (acc << 1) + {{(AW-4){1'b0}}, digit};
        lim     = neg ? NEG_LIM : POS_LIM;
        ovf     = (prod > lim);
        acc_nxt = ovf ? lim : prod;
    end
endmodule

// File: rtl/ascii_stream_num_parser.sv
// Streaming ASCII decimal list parser: converts a byte packet into signed words written to external RAM.
//
// state    | meaning
// ST_IDLE  | waiting for first byte of a packet
// ST_GAP   | between numbers (after a delimiter)
// ST_SIGN  | '-' seen, waiting for first digit
// ST_DIGIT | accumulating digits of a number
// ST_DRAIN | packet is invalid, discarding bytes until last
// ST_DONE  | packet finished, holding results until clear
module ascii_stream_num_parser
    import ascii_sep_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_COUNT  = 2048,
    parameter int SAT_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    ascii_stream_num_parser_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  invalid,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   num_count
);
    localparam int AW = DATA_WIDTH + 4;
    localparam logic [ADDR_WIDTH:0] MAX_CNT = MAX_COUNT[ADDR_WIDTH:0];

    state_t                state_q, state_d;
    char_class_t           cls;
    logic                  accept;
    logic [3:0]            digit;
    logic [AW-1:0]         acc_q, acc_nxt, acc_new;
    logic                  neg_q, acc_ovf;
    logic                  acc_ld, neg_set, flush, set_inv, set_ovf;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic                  wr_en_q, invalid_q, ovf_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    assign bus.pkt_payload_ready = (state_q != ST_DONE);
    assign accept = bus.pkt_payload_valid && bus.pkt_payload_ready;
    assign cls    = classify(bus.pkt_payload_data);
    assign digit  = bus.pkt_payload_data[3:0];

    dec_accumulator #(.DATA_WIDTH(DATA_WIDTH)) u_dec_acc (
        .acc     (acc_q),
        .digit   (digit),
        .neg     (neg_q),
        .acc_nxt (acc_nxt),
        .ovf     (acc_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        acc_ld  = 1'b0;
        neg_set = 1'b0;
        flush   = 1'b0;
        set_inv = 1'b0;
        set_ovf = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    case (cls)
                        CC_DIGIT: begin acc_ld = 1'b1; state_d = ST_DIGIT; end
                        CC_SIGN:  begin neg_set = 1'b1; state_d = ST_SIGN; end
                        CC_DELIM: state_d = ST_GAP;
                        default:  begin set_inv = 1'b1; state_d = ST_DRAIN; end
                    endcase
                end
                ST_SIGN: begin
                    if (cls == CC_DIGIT) begin
                        acc_ld  = 1'b1;
                        state_d = ST_DIGIT;
                    end else begin
                        set_inv = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
                ST_DIGIT: begin
                    case (cls)
                        CC_DIGIT: acc_ld = 1'b1;
                        CC_DELIM: begin flush = 1'b1; state_d = ST_GAP; end
                        default:  begin set_inv = 1'b1; state_d = ST_DRAIN; end
                    endcase
                end
                default: ;
            endcase

            if (acc_ld && acc_ovf) begin
                set_ovf = 1'b1;
                if (SAT_MODE == 0) begin
                    acc_ld  = 1'b0;
                    set_inv = 1'b1;
                    state_d = ST_DRAIN;
                end
            end

            // last byte closes the packet, flushing a number that is still open
            if (bus.pkt_payload_last) begin
                if (state_d == ST_DIGIT)
                    flush = 1'b1;
                state_d = ST_DONE;
            end

            if (flush && cnt_q == MAX_CNT) begin
                flush   = 1'b0;
                set_inv = 1'b1;
                if (!bus.pkt_payload_last)
                    state_d = ST_DRAIN;
            end
        end
        if (clear)
            state_d = ST_IDLE;
    end

    assign acc_new = acc_ld ? acc_nxt : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            invalid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (clear) begin
            acc_q     <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            invalid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_en_q <= flush;
            if (flush) begin
                wr_addr_q <= cnt_q[ADDR_WIDTH-1:0];
                wr_data_q <= DATA_WIDTH'(neg_q ? -acc_new : acc_new);
                cnt_q     <= cnt_q + (ADDR_WIDTH+1)'(1);
            end
            if (set_inv)
                invalid_q <= 1'b1;
            if (set_ovf)
                ovf_q <= 1'b1;
            // the partial number only survives while a number is actually open
            if (state_d == ST_DIGIT) begin
                if (acc_ld)
                    acc_q <= acc_nxt;
            end else begin
                acc_q <= '0;
            end
            if (neg_set)
                neg_q <= 1'b1;
            else if (state_d != ST_SIGN && state_d != ST_DIGIT)
                neg_q <= 1'b0;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign invalid     = invalid_q;
    assign overflow    = ovf_q;
    assign num_count   = cnt_q;
endmodule

// File: tb/tb_ascii_stream_num_parser.sv
// Drives the same packets into three parser configurations and checks them against a token-level model.
module tb_ascii_stream_num_parser;
    localparam int N_DUT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;

    always #5 clk = ~clk;

    // dut 0: 32-bit, invalid on overflow; dut 1: 8-bit saturating, 4 numbers; dut 2: 8-bit, 2 numbers
    ascii_stream_num_parser_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) if_a ();
    ascii_stream_num_parser_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(2))  if_s ();
    ascii_stream_num_parser_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(2))  if_z ();

    assign if_a.pkt_payload_data = s_data;  assign if_a.pkt_payload_valid = s_valid;  assign if_a.pkt_payload_last = s_last;
    assign if_s.pkt_payload_data = s_data;  assign if_s.pkt_payload_valid = s_valid;  assign if_s.pkt_payload_last = s_last;
    assign if_z.pkt_payload_data = s_data;  assign if_z.pkt_payload_valid = s_valid;  assign if_z.pkt_payload_last = s_last;

    logic        busy_a, busy_s, busy_z, done_a, done_s, done_z;
    logic        inv_a, inv_s, inv_z, ovf_a, ovf_s, ovf_z;
    logic [11:0] cnt_a;
    logic [2:0]  cnt_s, cnt_z;

    ascii_stream_num_parser #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .MAX_COUNT(2048), .SAT_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_a), .busy(busy_a), .done(done_a),
        .invalid(inv_a), .overflow(ovf_a), .num_count(cnt_a));
    ascii_stream_num_parser #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .MAX_COUNT(4), .SAT_MODE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_s), .busy(busy_s), .done(done_s),
        .invalid(inv_s), .overflow(ovf_s), .num_count(cnt_s));
    ascii_stream_num_parser #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .MAX_COUNT(2), .SAT_MODE(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_z), .busy(busy_z), .done(done_z),
        .invalid(inv_z), .overflow(ovf_z), .num_count(cnt_z));

    logic        wr_en_v[N_DUT], rdy_v[N_DUT], busy_v[N_DUT], done_v[N_DUT], inv_v[N_DUT], ovf_v[N_DUT];
    logic [31:0] wr_data_v[N_DUT];
    logic [10:0] wr_addr_v[N_DUT];
    logic [11:0] cnt_v[N_DUT];

    assign wr_en_v[0] = if_a.wr_en;  assign wr_en_v[1] = if_s.wr_en;  assign wr_en_v[2] = if_z.wr_en;
    assign rdy_v[0] = if_a.pkt_payload_ready;  assign rdy_v[1] = if_s.pkt_payload_ready;  assign rdy_v[2] = if_z.pkt_payload_ready;
    assign wr_data_v[0] = if_a.wr_data;
    assign wr_data_v[1] = {{24{if_s.wr_data[7]}}, if_s.wr_data};
    assign wr_data_v[2] = {{24{if_z.wr_data[7]}}, if_z.wr_data};
    assign wr_addr_v[0] = if_a.wr_addr;  assign wr_addr_v[1] = {9'd0, if_s.wr_addr};  assign wr_addr_v[2] = {9'd0, if_z.wr_addr};
    assign cnt_v[0] = cnt_a;  assign cnt_v[1] = {9'd0, cnt_s};  assign cnt_v[2] = {9'd0, cnt_z};
    assign busy_v[0] = busy_a;  assign busy_v[1] = busy_s;  assign busy_v[2] = busy_z;
    assign done_v[0] = done_a;  assign done_v[1] = done_s;  assign done_v[2] = done_z;
    assign inv_v[0] = inv_a;    assign inv_v[1] = inv_s;    assign inv_v[2] = inv_z;
    assign ovf_v[0] = ovf_a;    assign ovf_v[1] = ovf_s;    assign ovf_v[2] = ovf_z;

    int     w_tab[N_DUT]   = '{32, 8, 8};
    int     sat_tab[N_DUT] = '{0, 1, 0};
    int     max_tab[N_DUT] = '{2048, 4, 2};

    longint exp_val[N_DUT][$];
    int     exp_idx[N_DUT][$];
    bit     exp_inv[N_DUT];
    bit     exp_ovf[N_DUT];
    int     exp_cnt[N_DUT];
    int     seen[N_DUT];
    int     acc_cyc[64];
    int     cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Token-level model: split on delimiters, validate each token as -?[0-9]+ left to right.
    task automatic model_packet(input int k, input string s);
        longint poslim, neglim, mag, lim;
        bit     neg, bad, hasd, stop, dl;
        byte    tq[$];
        byte    c;
        poslim = (longint'(1) << (w_tab[k] - 1)) - 1;
        neglim = poslim + 1;
        exp_val[k].delete();
        exp_idx[k].delete();
        exp_inv[k] = 0;
        exp_ovf[k] = 0;
        exp_cnt[k] = 0;
        stop = 0;
        for (int i = 0; i < s.len() && !stop; i++) begin
            c  = s[i];
            dl = (c == 8'h20) || (c == 8'h2C) || (c == 8'h0D) || (c == 8'h0A);
            if (!dl) tq.push_back(c);
            if ((dl || i == s.len() - 1) && tq.size() > 0) begin
                neg = 0; bad = 0; hasd = 0; mag = 0;
                foreach (tq[j]) begin
                    if (!bad) begin
                        if (tq[j] == 8'h2D && j == 0) begin
                            neg = 1;
                        end else if (tq[j] >= 8'h30 && tq[j] <= 8'h39) begin
                            hasd = 1;
                            mag  = mag * 10 + (longint'(tq[j]) - 48);
                            lim  = neg ? neglim : poslim;
                            if (mag > lim) begin
                                exp_ovf[k] = 1;
                                if (sat_tab[k] != 0) mag = lim;
                                else bad = 1;
                            end
                        end else begin
                            bad = 1;
                        end
                    end
                end
                if (!hasd) bad = 1;
                if (bad || exp_cnt[k] == max_tab[k]) begin
                    exp_inv[k] = 1;
                    stop = 1;
                end else begin
                    exp_val[k].push_back(neg ? -mag : mag);
                    exp_idx[k].push_back(i);
                    exp_cnt[k]++;
                end
                tq.delete();
            end
        end
    endtask

    // Every write must match the model's next value, address, count and the one-cycle latency.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            if (wr_en_v[k]) begin
                n_cmp++;
                if (exp_val[k].size() == 0) begin
                    n_fail++;
                    $display("FAIL d%0d_unexpected_write: got addr %0d data %0d, required no write",
                             k, wr_addr_v[k], $signed(wr_data_v[k]));
                end else begin
                    longint ev;
                    int     ei;
                    ev = exp_val[k].pop_front();
                    ei = exp_idx[k].pop_front();
                    if (wr_data_v[k] !== 32'(ev) || wr_addr_v[k] !== 11'(seen[k]) ||
                        cnt_v[k] !== 12'(seen[k] + 1) || cyc != acc_cyc[ei] + 1) begin
                        n_fail++;
                        $display("FAIL d%0d_write: got data %0d addr %0d cnt %0d cycle %0d, required data %0d addr %0d cnt %0d cycle %0d",
                                 k, $signed(wr_data_v[k]), wr_addr_v[k], cnt_v[k], cyc,
                                 ev, seen[k], seen[k] + 1, acc_cyc[ei] + 1);
                    end
                    seen[k]++;
                end
            end
        end
    end

    task automatic send(input string s, input bit with_last, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            if (gap > 0 && i > 0) begin
                s_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            s_data  = s[i];
            s_valid = 1'b1;
            s_last  = with_last && (i == s.len() - 1);
            n_cmp++;
            if (!(rdy_v[0] && rdy_v[1] && rdy_v[2])) begin
                n_fail++;
                $display("FAIL ready_byte%0d: got %b%b%b, required 111", i, rdy_v[0], rdy_v[1], rdy_v[2]);
            end
            @(posedge clk);
            acc_cyc[i] = cyc;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic prep(input string s);
        for (int k = 0; k < N_DUT; k++) begin
            model_packet(k, s);
            seen[k] = 0;
        end
    endtask

    task automatic run_and_check(input string s, input int gap);
        send(s, 1'b1, gap);
        repeat (3) @(negedge clk);
        for (int k = 0; k < N_DUT; k++) begin
            chk($sformatf("d%0d_done", k), done_v[k], 1);
            chk($sformatf("d%0d_busy", k), busy_v[k], 0);
            chk($sformatf("d%0d_ready_in_done", k), rdy_v[k], 0);
            chk($sformatf("d%0d_invalid", k), inv_v[k], exp_inv[k]);
            chk($sformatf("d%0d_overflow", k), ovf_v[k], exp_ovf[k]);
            chk($sformatf("d%0d_num_count", k), cnt_v[k], exp_cnt[k]);
            chk($sformatf("d%0d_missing_writes", k), exp_val[k].size(), 0);
        end
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        chk("after_clear_done", done_v[0], 0);
        chk("after_clear_count", cnt_v[0], 0);
        chk("after_clear_invalid", inv_v[0], 0);
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < N_DUT; k++) begin
            chk($sformatf("%s_d%0d_wr_en", tag, k), wr_en_v[k], 0);
            chk($sformatf("%s_d%0d_wr_addr", tag, k), wr_addr_v[k], 0);
            chk($sformatf("%s_d%0d_wr_data", tag, k), wr_data_v[k], 0);
            chk($sformatf("%s_d%0d_done", tag, k), done_v[k], 0);
            chk($sformatf("%s_d%0d_busy", tag, k), busy_v[k], 0);
            chk($sformatf("%s_d%0d_invalid", tag, k), inv_v[k], 0);
            chk($sformatf("%s_d%0d_overflow", tag, k), ovf_v[k], 0);
            chk($sformatf("%s_d%0d_count", tag, k), cnt_v[k], 0);
            chk($sformatf("%s_d%0d_ready", tag, k), rdy_v[k], 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        prep("12,-7 300");
        chk("pin_p1_size", exp_val[0].size(), 3);
        chk("pin_p1_v0", exp_val[0][0], 12);
        chk("pin_p1_v1", exp_val[0][1], -7);
        chk("pin_p1_v2", exp_val[0][2], 300);
        run_and_check("12,-7 300", 0);
        prep("12,-7 300");
        run_and_check("12,-7 300", 2);

        prep("127 128 -128 -129");
        chk("pin_sat_v1", exp_val[1][1], 127);
        chk("pin_sat_v3", exp_val[1][3], -128);
        chk("pin_sat_ovf", exp_ovf[1], 1);
        chk("pin_nosat_size", exp_val[2].size(), 1);
        chk("pin_nosat_inv", exp_inv[2], 1);
        run_and_check("127 128 -128 -129", 0);

        prep("5,x,6");
        chk("pin_illegal_size", exp_val[0].size(), 1);
        chk("pin_illegal_inv", exp_inv[0], 1);
        run_and_check("5,x,6", 1);

        prep("1 2 3");
        chk("pin_max_cnt", exp_cnt[2], 2);
        chk("pin_max_inv", exp_inv[2], 1);
        run_and_check("1 2 3", 0);

        prep(" ");
        chk("pin_empty_cnt", exp_cnt[0], 0);
        run_and_check(" ", 0);

        prep("0007\015\012-0,--1");
        run_and_check("0007\015\012-0,--1", 0);

        prep("2147483647 -2147483648 2147483648");
        run_and_check("2147483647 -2147483648 2147483648", 0);

        // reset in the middle of a number: no write, everything back to zero
        for (int k = 0; k < N_DUT; k++) begin
            exp_val[k].delete(); exp_idx[k].delete(); seen[k] = 0;
        end
        send("45", 1'b0, 0);
        chk("midpkt_busy", busy_v[0], 1);
        chk("midpkt_done", done_v[0], 0);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        @(negedge clk) rst_n = 1'b1;
        prep("9");
        chk("pin_after_reset", exp_val[0][0], 9);
        run_and_check("9", 0);

        // clear mid-number with a byte offered in the same cycle: byte dropped, number discarded
        send("-3", 1'b0, 0);
        @(negedge clk);
        clear = 1'b1; s_data = 8'h37; s_valid = 1'b1; s_last = 1'b0;
        @(negedge clk);
        clear = 1'b0; s_valid = 1'b0;
        chk("clear_busy", busy_v[0], 0);
        chk("clear_count", cnt_v[0], 0);
        prep("4");
        run_and_check("4", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
